// File: rtl/stack_ctx_ctrl_if.sv
// Bundle of every non-clock/reset signal around the stack context controller:
// CPU side, stack side, save/restore control and the sync RAM port.
// master = the controller; slave = the surrounding CPU, stack and RAM.
interface stack_ctx_ctrl_if #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10
);
  localparam int DW = $clog2(DEPTH + 2);  // holds 0..CAP where CAP = DEPTH+1

  // CPU -> controller
  logic              cpu_hold;
  logic              cpu_we;
  logic [1:0]        cpu_delta;
  logic [WIDTH-1:0]  cpu_wd;
  // controller <-> stack
  logic              stk_hold;
  logic              stk_we;
  logic [1:0]        stk_delta;
  logic [WIDTH-1:0]  stk_wd;
  logic [WIDTH-1:0]  stk_rd;
  // save/restore control and status
  logic              save_req;
  logic              rest_req;
  logic [ADDR_W-1:0] base;
  logic              busy;
  logic              done;
  logic [DW-1:0]     depth;
  logic              ovf;
  logic              unf;
  // sync RAM port, read data valid the cycle after the address
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    input  cpu_hold, cpu_we, cpu_delta, cpu_wd,
    output stk_hold, stk_we, stk_delta, stk_wd,
    input  stk_rd,
    input  save_req, rest_req, base,
    output busy, done, depth, ovf, unf,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cpu_hold, cpu_we, cpu_delta, cpu_wd,
    input  stk_hold, stk_we, stk_delta, stk_wd,
    output stk_rd,
    output save_req, rest_req, base,
    input  busy, done, depth, ovf, unf,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/stack_ctx_ctrl.sv
// Stack context controller: passes CPU ops to a shift-register stack, tracks depth
//   with sticky ovf/unf, and saves/restores the stack to/from a 1-cycle sync RAM.
// Latency: save = count+2 cycles req->done, restore = n+3; 1 cell/cycle streaming.
// Backpressure: while busy the CPU is ignored and must stall; requests outside IDLE are dropped.
// Ports: clk, rst_n (async active-low), bus (stack_ctx_ctrl_if.master, all other signals).
module stack_ctx_ctrl #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  stack_ctx_ctrl_if.master    bus
);
  localparam int CAP = DEPTH + 1;
  localparam int DW  = $clog2(CAP + 1);
  localparam logic [DW-1:0] CAP_V = DW'(CAP);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_SAVE_N, S_R_CNT, S_R_WAIT, S_FILL, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     depth_q;
  logic              ovf_q, unf_q;
  logic [ADDR_W-1:0] ab_q;
  logic [DW-1:0]     cnt_q;   // saved count during save, clamped fill count during restore
  logic [DW-1:0]     idx_q;   // pushes already done in FILL
  logic              inc, dec;
  logic              cpu_inc, cpu_dec;
  logic [DW-1:0]     n_clamp;

  // Saturating depth step; the flags are raised separately from the same condition.
  function automatic logic [DW-1:0] step(input logic [DW-1:0] d, input logic up, input logic dn);
    if (up && d != CAP_V) return d + 1'b1;
    if (dn && d != '0)    return d - 1'b1;
    return d;
  endfunction

  assign cpu_inc = !bus.cpu_hold && bus.cpu_delta[0] && !bus.cpu_delta[1];
  assign cpu_dec = !bus.cpu_hold && bus.cpu_delta[0] &&  bus.cpu_delta[1];
  assign n_clamp = (bus.mem_rdata > WIDTH'(CAP)) ? CAP_V : bus.mem_rdata[DW-1:0];

  assign bus.depth = depth_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ab_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_nxt;
      depth_q <= step(depth_q, inc, dec);
      ovf_q   <= ovf_q | (inc && depth_q == CAP_V);
      unf_q   <= unf_q | (dec && depth_q == '0);
      // Count latched after any CPU op in the same cycle so the saved header matches.
      if (state == S_IDLE && (bus.save_req || bus.rest_req)) begin
        ab_q  <= bus.base;
        cnt_q <= step(depth_q, inc, dec);
      end
      if (state == S_R_WAIT) begin
        cnt_q <= n_clamp;
        idx_q <= '0;
      end
      if (state == S_FILL) idx_q <= idx_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.stk_hold  = 1'b0;
    bus.stk_we    = 1'b0;
    bus.stk_delta = 2'b00;
    bus.stk_wd    = '0;
    bus.mem_addr  = ab_q;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    inc           = 1'b0;
    dec           = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        bus.stk_hold  = bus.cpu_hold;
        bus.stk_we    = bus.cpu_we;
        bus.stk_delta = bus.cpu_delta;
        bus.stk_wd    = bus.cpu_wd;
        inc           = cpu_inc;
        dec           = cpu_dec;
        if (state == S_DONE) begin
          bus.done  = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.save_req) begin
          state_nxt = (step(depth_q, cpu_inc, cpu_dec) == '0) ? S_SAVE_N : S_SAVE;
        end else if (bus.rest_req) begin
          state_nxt = S_R_CNT;
        end
      end
      S_SAVE: begin
        // Top goes to the highest address, so bottom ends up at ab+1.
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ab_q + ADDR_W'(depth_q);
        bus.mem_wdata = bus.stk_rd;
        bus.stk_delta = 2'b11;
        dec           = 1'b1;
        if (depth_q == DW'(1)) state_nxt = S_SAVE_N;
      end
      S_SAVE_N: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = WIDTH'(cnt_q);
        state_nxt     = S_DONE;
      end
      S_R_CNT: begin
        bus.busy  = 1'b1;
        state_nxt = S_R_WAIT;
      end
      S_R_WAIT: begin
        // First cell's read is issued while the count is arriving.
        bus.busy     = 1'b1;
        bus.mem_addr = ab_q + ADDR_W'(1);
        state_nxt    = (n_clamp == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        // Push the cell read last cycle, read one ahead (the final read-ahead is unused).
        bus.busy      = 1'b1;
        bus.mem_addr  = ab_q + ADDR_W'(idx_q) + ADDR_W'(2);
        bus.stk_we    = 1'b1;
        bus.stk_delta = 2'b01;
        bus.stk_wd    = bus.mem_rdata;
        inc           = 1'b1;
        if (idx_q == cnt_q - 1'b1) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
